// File: rtl/pixel_coord_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// pixel_coord_sequencer_pkg
//   Shared constants, types and small helpers for the 96x64 OLED pixel
//   coordinate sequencer. No ports.
// -----------------------------------------------------------------------------
package pixel_coord_sequencer_pkg;

  localparam int unsigned WIDTH      = 96;
  localparam int unsigned HEIGHT     = 64;
  localparam int unsigned NUM_PIXELS = 6144;
  localparam int unsigned IDX_W      = 13;
  localparam int unsigned X_W        = 7;
  localparam int unsigned Y_W        = 6;

  typedef enum logic [0:0] {
    ST_TRACK  = 1'b0,
    ST_RESYNC = 1'b1
  } state_e;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } coord_t;

  // Linear index that follows idx in raster order, wrapping at the last pixel.
  function automatic logic [IDX_W-1:0] next_index(input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] r;
    if (idx == IDX_W'(NUM_PIXELS - 1)) begin
      r = '0;
    end else begin
      r = idx + IDX_W'(1);
    end
    return r;
  endfunction

  // Coordinate that follows c in raster order, wrapping at the bottom-right pixel.
  function automatic coord_t next_coord(input coord_t c);
    coord_t r;
    if (c.x == X_W'(WIDTH - 1)) begin
      r.x = '0;
      if (c.y == Y_W'(HEIGHT - 1)) begin
        r.y = '0;
      end else begin
        r.y = c.y + Y_W'(1);
      end
    end else begin
      r.x = c.x + X_W'(1);
      r.y = c.y;
    end
    return r;
  endfunction

  // True when idx addresses a real pixel.
  function automatic logic idx_legal(input logic [IDX_W-1:0] idx);
    return (idx < IDX_W'(NUM_PIXELS));
  endfunction

endpackage

// File: rtl/pixel_coord_sequencer_if.sv
// -----------------------------------------------------------------------------
// pixel_coord_sequencer_if
//   Bundles the OLED driver's index strobe with the coordinate results.
//   master : OLED driver side (drives sample/pixel_index, reads results)
//   slave  : sequencer side (reads sample/pixel_index, drives results)
//   Signals: sample, pixel_index[IDX_W], x[X_W], y[Y_W], coord_valid,
//            frame_start, busy, idx_err.
// -----------------------------------------------------------------------------
interface pixel_coord_sequencer_if;
  import pixel_coord_sequencer_pkg::*;

  logic             sample;
  logic [IDX_W-1:0] pixel_index;
  logic [X_W-1:0]   x;
  logic [Y_W-1:0]   y;
  logic             coord_valid;
  logic             frame_start;
  logic             busy;
  logic             idx_err;

  modport master (
    output sample, pixel_index,
    input  x, y, coord_valid, frame_start, busy, idx_err
  );

  modport slave (
    input  sample, pixel_index,
    output x, y, coord_valid, frame_start, busy, idx_err
  );

endinterface

// File: rtl/pixel_coord_sequencer_coord_divider.sv
// -----------------------------------------------------------------------------
// coord_divider
//   Iterative divide-by-WIDTH: one subtraction per clock.
//   clock_i  : clock
//   reset_i  : synchronous active-high reset (aborts a running division)
//   start_i  : load index_i and begin dividing
//   index_i  : dividend (legal pixel index)
//   done_o   : remainder is below WIDTH; rem_o/quot_o are final this cycle
//   rem_o    : remainder (column), only meaningful with done_o
//   quot_o   : quotient (row), only meaningful with done_o
// -----------------------------------------------------------------------------
module coord_divider
  import pixel_coord_sequencer_pkg::*;
(
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [IDX_W-1:0] index_i,
  output logic             done_o,
  output logic [X_W-1:0]   rem_o,
  output logic [Y_W-1:0]   quot_o
);

  logic             active_q, active_d;
  logic [IDX_W-1:0] rem_q, rem_d;
  logic [Y_W-1:0]   quot_q, quot_d;
  logic             rem_small_s;

  assign rem_small_s = (rem_q < IDX_W'(WIDTH));
  assign done_o      = active_q && rem_small_s;
  // Once done, the remainder is below WIDTH and fits the column width.
  assign rem_o       = rem_q[X_W-1:0];
  assign quot_o      = quot_q;

  // Division state registers.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      active_q <= 1'b0;
      rem_q    <= '0;
      quot_q   <= '0;
    end else begin
      active_q <= active_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
    end
  end

  // Load on start, subtract while remainder >= WIDTH, go idle after reporting.
  always_comb begin
    active_d = active_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    if (start_i) begin
      active_d = 1'b1;
      rem_d    = index_i;
      quot_d   = '0;
    end else if (active_q) begin
      if (!rem_small_s) begin
        rem_d  = rem_q - IDX_W'(WIDTH);
        quot_d = quot_q + Y_W'(1);
      end else begin
        active_d = 1'b0;
      end
    end else begin
      active_d = 1'b0;
    end
  end

endmodule

// File: rtl/pixel_coord_sequencer.sv
// -----------------------------------------------------------------------------
// pixel_coord_sequencer
//   Converts the OLED driver's linear pixel_index stream into registered (x, y)
//   coordinates. In-order indices take a one-cycle incremental path; any other
//   legal index is resolved by the iterative coord_divider.
//   clock_i : clock, all logic on posedge
//   reset_i : synchronous active-high reset
//   pix_if  : slave side of pixel_coord_sequencer_if
//             (sample, pixel_index in; x, y, coord_valid, frame_start, busy,
//              idx_err out, all registered)
// -----------------------------------------------------------------------------
module pixel_coord_sequencer
  import pixel_coord_sequencer_pkg::*;
(
  input  logic                     clock_i,
  input  logic                     reset_i,
  pixel_coord_sequencer_if.slave   pix_if
);

  state_e           state_q, state_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic             cv_q, cv_d;
  logic             fs_q, fs_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] exp_idx_q, exp_idx_d;
  // Coordinate of exp_idx_q, kept alongside so the fast path needs no divide.
  coord_t           exp_c_q, exp_c_d;
  logic             pend_q, pend_d;
  logic [IDX_W-1:0] pend_idx_q, pend_idx_d;
  logic [IDX_W-1:0] rs_idx_q, rs_idx_d;

  logic             div_start_s;
  logic [IDX_W-1:0] div_index_s;
  logic             div_done_s;
  logic [X_W-1:0]   div_rem_s;
  logic [Y_W-1:0]   div_quot_s;
  logic             cand_valid_s;
  logic [IDX_W-1:0] cand_idx_s;
  logic             live_legal_s;
  coord_t           done_c_s;

  coord_divider u_div (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .start_i (div_start_s),
    .index_i (div_index_s),
    .done_o  (div_done_s),
    .rem_o   (div_rem_s),
    .quot_o  (div_quot_s)
  );

  assign live_legal_s = idx_legal(pix_if.pixel_index);
  assign done_c_s     = '{x: div_rem_s, y: div_quot_s};

  assign pix_if.x           = x_q;
  assign pix_if.y           = y_q;
  assign pix_if.coord_valid = cv_q;
  assign pix_if.frame_start = fs_q;
  assign pix_if.busy        = busy_q;
  assign pix_if.idx_err     = err_q;

  // State, output and bookkeeping registers.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= ST_TRACK;
      x_q        <= '0;
      y_q        <= '0;
      cv_q       <= 1'b0;
      fs_q       <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      exp_idx_q  <= '0;
      exp_c_q    <= '0;
      pend_q     <= 1'b0;
      pend_idx_q <= '0;
      rs_idx_q   <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      cv_q       <= cv_d;
      fs_q       <= fs_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      exp_idx_q  <= exp_idx_d;
      exp_c_q    <= exp_c_d;
      pend_q     <= pend_d;
      pend_idx_q <= pend_idx_d;
      rs_idx_q   <= rs_idx_d;
    end
  end

  // Next-state logic: fast path, resync launch/completion and pending capture.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    cv_d         = 1'b0;
    err_d        = 1'b0;
    busy_d       = busy_q;
    exp_idx_d    = exp_idx_q;
    exp_c_d      = exp_c_q;
    pend_d       = pend_q;
    pend_idx_d   = pend_idx_q;
    rs_idx_d     = rs_idx_q;
    div_start_s  = 1'b0;
    div_index_s  = rs_idx_q;
    cand_valid_s = 1'b0;
    cand_idx_s   = pix_if.pixel_index;

    case (state_q)
      ST_TRACK: begin
        // A left-over pending index is served before the live strobe; a live
        // strobe in the same cycle then becomes the new pending entry.
        if (pend_q) begin
          cand_valid_s = 1'b1;
          cand_idx_s   = pend_idx_q;
          pend_d       = 1'b0;
          if (pix_if.sample) begin
            if (live_legal_s) begin
              pend_d     = 1'b1;
              pend_idx_d = pix_if.pixel_index;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            pend_d = 1'b0;
          end
        end else if (pix_if.sample) begin
          if (live_legal_s) begin
            cand_valid_s = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cand_valid_s = 1'b0;
        end

        if (cand_valid_s) begin
          if (cand_idx_s == exp_idx_q) begin
            x_d       = exp_c_q.x;
            y_d       = exp_c_q.y;
            cv_d      = 1'b1;
            exp_idx_d = next_index(cand_idx_s);
            exp_c_d   = next_coord(exp_c_q);
          end else begin
            div_start_s = 1'b1;
            div_index_s = cand_idx_s;
            rs_idx_d    = cand_idx_s;
            busy_d      = 1'b1;
            state_d     = ST_RESYNC;
          end
        end else begin
          state_d = ST_TRACK;
        end
      end

      ST_RESYNC: begin
        // Newest legal strobe wins the one-deep pending slot.
        if (pix_if.sample) begin
          if (live_legal_s) begin
            pend_d     = 1'b1;
            pend_idx_d = pix_if.pixel_index;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          pend_d = pend_q;
        end

        if (div_done_s) begin
          x_d       = div_rem_s;
          y_d       = div_quot_s;
          cv_d      = 1'b1;
          exp_idx_d = next_index(rs_idx_q);
          exp_c_d   = next_coord(done_c_s);
          busy_d    = 1'b0;
          state_d   = ST_TRACK;
        end else begin
          state_d = ST_RESYNC;
        end
      end

      default: begin
        state_d = ST_TRACK;
        busy_d  = 1'b0;
        pend_d  = 1'b0;
      end
    endcase

    fs_d = cv_d && (x_d == '0) && (y_d == '0);
  end

endmodule

// File: tb/tb_pixel_coord_sequencer.sv
module tb_pixel_coord_sequencer;
  import pixel_coord_sequencer_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  pixel_coord_sequencer_if pif ();

  pixel_coord_sequencer dut (
    .clock_i (clk),
    .reset_i (rst),
    .pix_if  (pif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance one clock and sample outputs 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_sample(input int idx);
    pif.sample      = 1'b1;
    pif.pixel_index = IDX_W'(idx);
    tick();
    pif.sample      = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_cv(input int budget, output int cycles, output logic seen);
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < budget) begin
      tick();
      cycles++;
      if (pif.coord_valid === 1'b1) seen = 1'b1;
    end
  endtask

  initial begin
    int   cyc;
    logic seen;
    int   n_cv;
    int   n_busy;

    total           = 0;
    bad             = 0;
    rst             = 1'b0;
    pif.sample      = 1'b0;
    pif.pixel_index = '0;
    #2;

    // Reset state.
    do_reset();
    chk("rst_x", pif.x, 0);
    chk("rst_y", pif.y, 0);
    chk("rst_cv", pif.coord_valid, 0);
    chk("rst_fs", pif.frame_start, 0);
    chk("rst_busy", pif.busy, 0);
    chk("rst_err", pif.idx_err, 0);

    // 1: full raster sweep on the fast path, then wrap to 0.
    for (int i = 0; i < 6144; i++) begin
      do_sample(i);
      chk("sweep_cv", pif.coord_valid, 1);
      chk("sweep_x", pif.x, i % 96);
      chk("sweep_y", pif.y, i / 96);
      chk("sweep_fs", pif.frame_start, (i == 0) ? 1 : 0);
      chk("sweep_busy", pif.busy, 0);
    end
    do_sample(0);
    chk("wrap_cv", pif.coord_valid, 1);
    chk("wrap_x", pif.x, 0);
    chk("wrap_y", pif.y, 0);
    chk("wrap_fs", pif.frame_start, 1);
    tick();
    chk("wrap_cv_pulse", pif.coord_valid, 0);
    chk("wrap_fs_pulse", pif.frame_start, 0);

    // 2: row crossing on the fast path (95 -> 96).
    do_reset();
    n_busy = 0;
    for (int i = 0; i < 96; i++) begin
      do_sample(i);
      if (pif.busy === 1'b1) n_busy++;
    end
    chk("row_x95", pif.x, 95);
    do_sample(96);
    if (pif.busy === 1'b1) n_busy++;
    chk("row_cv", pif.coord_valid, 1);
    chk("row_x", pif.x, 0);
    chk("row_y", pif.y, 1);
    chk("row_fs", pif.frame_start, 0);
    chk("row_busy_never", n_busy, 0);

    // 3: worst-case resync on 6143 after reset.
    do_reset();
    do_sample(6143);
    chk("wc_busy0", pif.busy, 1);
    chk("wc_cv0", pif.coord_valid, 0);
    n_busy = 1;
    n_cv   = 0;
    for (int k = 0; k < 63; k++) begin
      tick();
      if (pif.busy === 1'b1) n_busy++;
      if (pif.coord_valid === 1'b1) n_cv++;
    end
    chk("wc_busy_cycles", n_busy, 64);
    chk("wc_no_early_cv", n_cv, 0);
    tick();
    chk("wc_cv", pif.coord_valid, 1);
    chk("wc_x", pif.x, 95);
    chk("wc_y", pif.y, 63);
    chk("wc_busy_done", pif.busy, 0);
    tick();
    chk("wc_cv_once", pif.coord_valid, 0);
    do_sample(0);
    chk("wc_next_cv", pif.coord_valid, 1);
    chk("wc_next_x", pif.x, 0);
    chk("wc_next_y", pif.y, 0);
    chk("wc_next_fs", pif.frame_start, 1);
    chk("wc_next_busy", pif.busy, 0);

    // 4: samples during resync; only the newest pending one is served.
    do_reset();
    do_sample(200);
    chk("pend_busy", pif.busy, 1);
    do_sample(500);
    do_sample(1000);
    chk("pend_cv_early", pif.coord_valid, 0);
    tick();
    chk("pend_cv1", pif.coord_valid, 1);
    chk("pend_x1", pif.x, 8);
    chk("pend_y1", pif.y, 2);
    chk("pend_busy_gap", pif.busy, 0);
    wait_cv(40, cyc, seen);
    chk("pend_seen2", seen, 1);
    chk("pend_x2", pif.x, 40);
    chk("pend_y2", pif.y, 10);
    chk("pend_lat2", cyc, 12);

    // 5: illegal index from TRACK.
    tick();
    do_sample(6144);
    chk("ill_err", pif.idx_err, 1);
    chk("ill_cv", pif.coord_valid, 0);
    chk("ill_x", pif.x, 40);
    chk("ill_y", pif.y, 10);
    chk("ill_busy", pif.busy, 0);
    tick();
    chk("ill_err_pulse", pif.idx_err, 0);
    do_sample(1001);
    chk("ill_track_cv", pif.coord_valid, 1);
    chk("ill_track_x", pif.x, 41);
    chk("ill_track_busy", pif.busy, 0);

    // Illegal index during resync is flagged and never served.
    do_sample(300);
    do_sample(7000);
    chk("rsill_err", pif.idx_err, 1);
    wait_cv(20, cyc, seen);
    chk("rsill_seen", seen, 1);
    chk("rsill_x", pif.x, 12);
    chk("rsill_y", pif.y, 3);
    chk("rsill_lat", cyc, 3);
    n_cv   = 0;
    n_busy = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (pif.coord_valid === 1'b1) n_cv++;
      if (pif.busy === 1'b1) n_busy++;
    end
    chk("rsill_no_cv", n_cv, 0);
    chk("rsill_no_busy", n_busy, 0);

    // 6: reset in the middle of resyncing 5000.
    do_sample(5000);
    for (int k = 0; k < 5; k++) tick();
    chk("rsrst_busy_before", pif.busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rsrst_x", pif.x, 0);
    chk("rsrst_y", pif.y, 0);
    chk("rsrst_busy", pif.busy, 0);
    chk("rsrst_cv", pif.coord_valid, 0);
    n_cv = 0;
    for (int k = 0; k < 70; k++) begin
      tick();
      if (pif.coord_valid === 1'b1) n_cv++;
    end
    chk("rsrst_no_cv", n_cv, 0);
    do_sample(0);
    chk("rsrst_fast_cv", pif.coord_valid, 1);
    chk("rsrst_fast_fs", pif.frame_start, 1);
    chk("rsrst_fast_x", pif.x, 0);
    chk("rsrst_fast_y", pif.y, 0);
    chk("rsrst_fast_busy", pif.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
